// File: rtl/lfsr_pkg.sv
// lfsr_pkg: shared definitions for the LFSR lock checker family.
//   lock_state_t  : lock FSM states (HUNT, LOCKED).
//   POLY_W*       : default Galois tap masks for common word widths.
//   lfsr_next()   : width-generic next-state function (up to LFSR_MAX_W bits)
//                   for code that prefers a function over lfsr_next_comb.
package lfsr_pkg;

   typedef enum logic {
      HUNT   = 1'b0,
      LOCKED = 1'b1
   } lock_state_t;

   localparam int LFSR_MAX_W = 32;

   // Tap masks: bit i set means next[i] is XORed with the feedback bit.
   localparam logic [3:0]  POLY_W4  = 4'h3;
   localparam logic [7:0]  POLY_W8  = 8'h8D;
   localparam logic [15:0] POLY_W16 = 16'h100B;

   // Galois step. In extended mode the feedback is inverted when all bits
   // below the msb are zero, which splices the all-zero word into the cycle.
   function automatic logic [LFSR_MAX_W-1:0] lfsr_next(
      input logic [LFSR_MAX_W-1:0] x,
      input logic [LFSR_MAX_W-1:0] poly,
      input int                    width,
      input logic                  extended
   );
      logic                  fb;
      logic                  low_zero;
      logic [LFSR_MAX_W-1:0] y;
      low_zero = 1'b1;
      for (int i = 0; i < LFSR_MAX_W; i++) begin
         if (i < width - 1 && x[i]) low_zero = 1'b0;
      end
      fb   = x[width-1] ^ (extended & low_zero);
      y    = '0;
      y[0] = fb;
      for (int i = 1; i < LFSR_MAX_W; i++) begin
         if (i < width) y[i] = x[i-1] ^ (poly[i] & fb);
      end
      return y;
   endfunction

endpackage

// File: rtl/lfsr_next_comb.sv
// lfsr_next_comb: purely combinational one-step Galois LFSR advance.
//   x : current word (WIDTH bits)
//   y : successor word (WIDTH bits)
// EXTENDED=1 yields a 2^WIDTH period that includes the all-zero word.
module lfsr_next_comb #(
   parameter int               WIDTH    = 8,
   parameter logic [WIDTH-1:0] POLY     = 8'h8D,
   parameter bit               EXTENDED = 1'b1
) (
   input  logic [WIDTH-1:0] x,
   output logic [WIDTH-1:0] y
);

   logic fb;

   always_comb begin
      fb   = x[WIDTH-1] ^ (EXTENDED & (x[WIDTH-2:0] == '0));
      y    = '0;
      y[0] = fb;
      for (int i = 1; i < WIDTH; i++) begin
         y[i] = x[i-1] ^ (POLY[i] & fb);
      end
   end

endmodule

// File: rtl/lfsr_lock_checker.sv
// lfsr_lock_checker: receive-side checker for an LFSR/PRBS word stream.
// Hunts for LOCK_CNT consecutive correct successors (re-seeding from every
// received word), then free-runs its own reference and counts errors; drops
// lock after UNLOCK_CNT consecutive errors.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   i_valid      : i_LFSR carries a word this cycle
//   i_LFSR       : received word
//   i_clr_cnt    : synchronous clear of o_err_cnt (wins over an increment)
//   o_lock       : lock status
//   o_match      : pulse, last valid word was compared and matched
//   o_err        : pulse, last valid word mismatched while locked
//   o_err_cnt    : saturating error count
//   state_dbg    : lock FSM state (0 = HUNT, 1 = LOCKED)
// All outputs are registered; they respond one edge after the word.
module lfsr_lock_checker
   import lfsr_pkg::*;
#(
   parameter int               WIDTH      = 8,
   parameter logic [WIDTH-1:0] POLY       = POLY_W8,
   parameter bit               EXTENDED   = 1'b1,
   parameter int               LOCK_CNT   = 4,
   parameter int               UNLOCK_CNT = 3,
   parameter int               ERR_W      = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             i_valid,
   input  logic [WIDTH-1:0] i_LFSR,
   input  logic             i_clr_cnt,
   output logic             o_lock,
   output logic             o_match,
   output logic             o_err,
   output logic [ERR_W-1:0] o_err_cnt,
   output logic             state_dbg
);

   localparam logic [7:0] LOCK_TH   = 8'(LOCK_CNT);
   localparam logic [7:0] UNLOCK_TH = 8'(UNLOCK_CNT);

   lock_state_t      state, state_d;
   logic [WIDTH-1:0] ref_q, ref_d;
   logic [WIDTH-1:0] exp_word;
   logic             have_ref, have_ref_d;
   logic [7:0]       match_run, match_run_d;
   logic [7:0]       mis_run, mis_run_d;
   logic             match_d, err_d;
   logic [ERR_W-1:0] err_cnt_d;

   lfsr_next_comb #(
      .WIDTH    (WIDTH),
      .POLY     (POLY),
      .EXTENDED (EXTENDED)
   ) u_next (
      .x (ref_q),
      .y (exp_word)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= HUNT;
         ref_q     <= '0;
         have_ref  <= 1'b0;
         match_run <= '0;
         mis_run   <= '0;
         o_match   <= 1'b0;
         o_err     <= 1'b0;
         o_err_cnt <= '0;
      end else begin
         state     <= state_d;
         ref_q     <= ref_d;
         have_ref  <= have_ref_d;
         match_run <= match_run_d;
         mis_run   <= mis_run_d;
         o_match   <= match_d;
         o_err     <= err_d;
         o_err_cnt <= err_cnt_d;
      end
   end

   always_comb begin
      state_d     = state;
      ref_d       = ref_q;
      have_ref_d  = have_ref;
      match_run_d = match_run;
      mis_run_d   = mis_run;
      match_d     = 1'b0;
      err_d       = 1'b0;
      err_cnt_d   = o_err_cnt;

      if (i_valid) begin
         unique case (state)
            HUNT: begin
               // Self-sync: every received word becomes the new seed, so a
               // single bad word only costs the current run.
               ref_d      = i_LFSR;
               have_ref_d = 1'b1;
               if (have_ref) begin
                  if (i_LFSR == exp_word) begin
                     match_run_d = match_run + 8'd1;
                     match_d     = 1'b1;
                     if (match_run_d == LOCK_TH) begin
                        state_d   = LOCKED;
                        mis_run_d = '0;
                     end
                  end else begin
                     match_run_d = '0;
                  end
               end
            end
            LOCKED: begin
               // Free-run: the reference never follows the received data.
               ref_d = exp_word;
               if (i_LFSR == exp_word) begin
                  match_d   = 1'b1;
                  mis_run_d = '0;
               end else begin
                  err_d     = 1'b1;
                  mis_run_d = mis_run + 8'd1;
                  if (o_err_cnt != '1) err_cnt_d = o_err_cnt + ERR_W'(1);
                  if (mis_run_d == UNLOCK_TH) begin
                     state_d     = HUNT;
                     have_ref_d  = 1'b0;
                     match_run_d = '0;
                  end
               end
            end
            default: state_d = HUNT;
         endcase
      end

      if (i_clr_cnt) err_cnt_d = '0;
   end

   assign o_lock    = (state == LOCKED);
   assign state_dbg = state;

endmodule

// File: tb/tb_lfsr_lock_checker.sv
module tb_lfsr_lock_checker;

   localparam logic [7:0] POLY = 8'h8D;
   localparam int LOCK_CNT   = 4;
   localparam int UNLOCK_CNT = 3;
   localparam int CNT_MAX    = 65535;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic reset_n;
   always #5 clk = ~clk;

   // main instance (defaults)
   logic        i_valid, i_clr_cnt;
   logic [7:0]  lfsr_in;
   logic        o_lock, o_match, o_err, state_dbg;
   logic [15:0] o_err_cnt;

   // saturation instance (ERR_W=2, UNLOCK_CNT=255)
   logic        v2, c2;
   logic [7:0]  w2;
   logic        lock2, match2, err2, state2;
   logic [1:0]  cnt2;

   lfsr_lock_checker dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .i_valid   (i_valid),
      .i_LFSR    (lfsr_in),
      .i_clr_cnt (i_clr_cnt),
      .o_lock    (o_lock),
      .o_match   (o_match),
      .o_err     (o_err),
      .o_err_cnt (o_err_cnt),
      .state_dbg (state_dbg)
   );

   lfsr_lock_checker #(.ERR_W(2), .UNLOCK_CNT(255)) dut_sat (
      .clk       (clk),
      .reset_n   (reset_n),
      .i_valid   (v2),
      .i_LFSR    (w2),
      .i_clr_cnt (c2),
      .o_lock    (lock2),
      .o_match   (match2),
      .o_err     (err2),
      .o_err_cnt (cnt2),
      .state_dbg (state2)
   );

   // ---------------- scoreboard bookkeeping ----------------
   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // ---------------- reference model ----------------
   // Galois step as multiplication by x modulo the tap polynomial, with the
   // extended-mode feedback inversion when the low seven bits are zero.
   function automatic logic [7:0] nxt(input logic [7:0] x);
      logic fb;
      fb = x[7] ^ (x[6:0] == 7'd0);
      return 8'(x << 1) ^ (fb ? POLY : 8'h00);
   endfunction

   bit         m_locked, m_have, e_match, e_err;
   logic [7:0] m_ref;
   int         m_mrun, m_erun, m_cnt;

   task automatic model_reset();
      m_locked = 0; m_have = 0; e_match = 0; e_err = 0;
      m_ref = 8'h00; m_mrun = 0; m_erun = 0; m_cnt = 0;
   endtask

   task automatic model_word(input bit v, input logic [7:0] w, input bit c);
      logic [7:0] exp_w;
      e_match = 0;
      e_err   = 0;
      if (v) begin
         exp_w = nxt(m_ref);
         if (!m_locked) begin
            if (m_have) begin
               if (w == exp_w) begin
                  m_mrun++;
                  e_match = 1;
                  if (m_mrun == LOCK_CNT) begin
                     m_locked = 1;
                     m_erun   = 0;
                  end
               end else begin
                  m_mrun = 0;
               end
            end
            m_ref  = w;
            m_have = 1;
         end else begin
            m_ref = exp_w;
            if (w == exp_w) begin
               e_match = 1;
               m_erun  = 0;
            end else begin
               e_err = 1;
               if (m_cnt < CNT_MAX) m_cnt++;
               m_erun++;
               if (m_erun == UNLOCK_CNT) begin
                  m_locked = 0;
                  m_have   = 0;
                  m_mrun   = 0;
               end
            end
         end
      end
      if (c) m_cnt = 0;
   endtask

   // ---------------- driver tasks ----------------
   task automatic step(input bit v, input logic [7:0] w, input bit c);
      i_valid   = v;
      lfsr_in   = w;
      i_clr_cnt = c;
      model_word(v, w, c);
      @(posedge clk);
      #1;
      check("lock",  32'(o_lock),    32'(m_locked));
      check("match", 32'(o_match),   32'(e_match));
      check("err",   32'(o_err),     32'(e_err));
      check("cnt",   32'(o_err_cnt), 32'(m_cnt));
      check("state", 32'(state_dbg), 32'(m_locked));
      i_valid   = 1'b0;
      i_clr_cnt = 1'b0;
   endtask

   task automatic gap(input int n);
      for (int k = 0; k < n; k++) step(1'b0, 8'($urandom), 1'b0);
   endtask

   task automatic step_sat(input logic [7:0] w);
      v2 = 1'b1;
      w2 = w;
      @(posedge clk);
      #1;
      v2 = 1'b0;
   endtask

   // ---------------- directed + random sequence ----------------
   initial begin
      logic [7:0] seq_a [5];
      logic [7:0] g, w;
      int         burst;

      seq_a = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10};
      reset_n = 1'b0;
      i_valid = 1'b0; i_clr_cnt = 1'b0; lfsr_in = 8'h00;
      v2 = 1'b0; c2 = 1'b0; w2 = 8'h00;
      model_reset();

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_lock",  32'(o_lock),    0);
      check("rst_match", 32'(o_match),   0);
      check("rst_err",   32'(o_err),     0);
      check("rst_cnt",   32'(o_err_cnt), 0);
      check("rst_state", 32'(state_dbg), 0);
      reset_n = 1'b1;

      // Back-to-back lock: matches on words 2..5, lock after word 5
      for (int k = 0; k < 5; k++) begin
         step(1'b1, seq_a[k], 1'b0);
         check("a_match_pulse", 32'(o_match), (k >= 1) ? 1 : 0);
      end
      check("a_locked", 32'(o_lock), 1);

      // Locked at 10; send 21,41,81 (bit0 flipped) -> unlock after third error
      step(1'b1, 8'h21, 1'b0);
      step(1'b1, 8'h41, 1'b0);
      check("b_still_locked", 32'(o_lock), 1);
      step(1'b1, 8'h81, 1'b0);
      check("b_cnt3",     32'(o_err_cnt), 3);
      check("b_unlocked", 32'(o_lock),    0);

      // Same words with 1..3 invalid cycles between them: same word count to lock
      for (int k = 0; k < 5; k++) begin
         step(1'b1, seq_a[k], 1'b0);
         if (k == 3) check("c_not_yet", 32'(o_lock), 0);
         if (k < 4) gap($urandom_range(1, 3));
      end
      check("c_locked", 32'(o_lock), 1);

      // Clear, two errors, one correct word, two more errors: lock holds
      step(1'b0, 8'h00, 1'b1);
      check("d_clr", 32'(o_err_cnt), 0);
      step(1'b1, 8'h21, 1'b0);
      step(1'b1, 8'h41, 1'b0);
      step(1'b1, 8'h80, 1'b0);
      check("d_cnt2", 32'(o_err_cnt), 2);
      check("d_lock", 32'(o_lock),    1);
      step(1'b1, 8'h01, 1'b0);
      step(1'b1, 8'h8C, 1'b0);
      check("d_lock_after_reset_run", 32'(o_lock), 1);

      // Correct word, then an error coinciding with clear: clear wins
      step(1'b1, 8'h97, 1'b0);
      step(1'b1, 8'hA2, 1'b1);
      check("e_clr_wins", 32'(o_err_cnt), 0);
      check("e_err_pulse", 32'(o_err), 1);

      // Asynchronous reset while locked
      #2;
      reset_n = 1'b0;
      #1;
      check("f_async_lock", 32'(o_lock),    0);
      check("f_async_cnt",  32'(o_err_cnt), 0);
      model_reset();
      @(posedge clk);
      #1;
      reset_n = 1'b1;

      // Wrap through the all-zero word: 20,40,80,00,8D
      step(1'b1, 8'h20, 1'b0);
      step(1'b1, 8'h40, 1'b0);
      step(1'b1, 8'h80, 1'b0);
      step(1'b1, 8'h00, 1'b0);
      step(1'b1, 8'h8D, 1'b0);
      check("g_wrap_lock", 32'(o_lock), 1);

      // Randomized stream: gaps, error bursts, occasional generator jumps, clears
      g = 8'($urandom);
      burst = 0;
      for (int k = 0; k < 800; k++) begin
         if ($urandom_range(0, 3) == 0) begin
            step(1'b0, 8'($urandom), ($urandom_range(0, 39) == 0));
         end else begin
            if ($urandom_range(0, 79) == 0) g = 8'($urandom);
            g = nxt(g);
            if (burst == 0 && $urandom_range(0, 29) == 0) burst = $urandom_range(1, 5);
            w = g;
            if (burst > 0) begin
               w = g ^ 8'($urandom_range(1, 255));
               burst--;
            end
            step(1'b1, w, ($urandom_range(0, 39) == 0));
         end
      end

      // Saturation on the 2-bit counter instance
      for (int k = 0; k < 5; k++) step_sat(seq_a[k]);
      check("h_sat_lock", 32'(lock2), 1);
      begin
         logic [7:0] bad [5];
         bad = '{8'h21, 8'h41, 8'h81, 8'h01, 8'h8C};
         for (int k = 0; k < 5; k++) begin
            step_sat(bad[k]);
            check("h_sat_cnt",  32'(cnt2),  (k + 1 > 3) ? 3 : k + 1);
            check("h_sat_err",  32'(err2),  1);
            check("h_sat_held", 32'(lock2), 1);
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
